mau_tern_stage: RTL and testbench
=================================

Name: mau_tern_stage

Overview:
Parametrised ternary match-action stage, successor to mau_stage. Fixed key/table size becomes configurable key offset/width, entry count and action SRAM depth. Adds: configurable default (miss) action, field SET/ADD ops, full valid/ready backpressure. Sits in the ingress/egress MAU chain; one instance per stage, PHV in, PHV out.

Parameters:
STAGE_ID, 0, stage index (debug/trace only)
KEY_W, 512, match key width in bits
KEY_LSB, 0, PHV bit offset of key LSB; KEY_LSB+KEY_W <= PHV_BITS
N_ENT, 64, ternary entries (power of 2, 2..2048)
ASRAM_D, 256, action SRAM depth (power of 2)

Ports:
clk_dp  in  1  datapath clock
rst_dp_n  in  1  asynchronous active-low reset
in_valid  in  1  input PHV valid
in_ready  out  1  stage accepts input
in_data  in  PHV_BITS  input PHV
in_meta  in  phv_meta_t  input metadata
out_valid  out  1  output PHV valid
out_ready  in  1  downstream ready
out_data  out  PHV_BITS  output PHV
out_meta  out  phv_meta_t  output metadata
tcam_wr_en  in  1  TCAM entry write strobe
tcam_wr_addr  in  $clog2(N_ENT)  entry index
tcam_wr_key / tcam_wr_mask  in  KEY_W  key; mask bit 1 = don't care
tcam_wr_valid  in  1  entry valid bit
tcam_wr_aptr  in  16  action SRAM pointer (low $clog2(ASRAM_D) bits used)
asram_wr_en  in  1  action SRAM write strobe
asram_wr_addr  in  $clog2(ASRAM_D)  action SRAM index
asram_wr_data  in  128  {action_id[15:0], params[111:0]}
dflt_en  in  1  miss runs default action
dflt_aptr  in  16  default action SRAM pointer

Behaviour:
- Reset: out_valid=0, out_data=0, out_meta=0, in_ready=1; all entry valid bits 0; all pipe valid bits 0. SRAM contents not reset.
- Pipeline, 4 cycles accept-to-out_valid: S0 capture PHV, extract key=in_data[KEY_LSB+:KEY_W]; S1 compare all entries, hit_i = valid_i & (((key^key_i) & ~mask_i)==0), lowest index wins; S2 synchronous SRAM read at winner aptr (miss & dflt_en: dflt_aptr); S3 ALU, output register.
- Miss & !dflt_en: PHV/meta pass through unchanged.
- Handshake: stall = out_valid & !out_ready; stall freezes all stages; in_ready = !stall. Accept on in_valid&in_ready; out data stable while stalled. Full throughput 1 PHV/cycle with out_ready=1.
- Opcode = action_id[15:12]; imm = params[47:16]; fidx = params[15:0] (32-bit PHV word index):
  0x0 NOP; 0x9 DROP: meta.drop=1; 0xA SET_PORT: meta.eg_port=imm[4:0];
  0xB SET_FIELD: word[fidx]=imm; 0xC ADD_FIELD: word[fidx]=(word+imm) mod 2^32;
  other opcodes: NOP. fidx >= PHV_BITS/32: PHV unchanged, meta ops still apply.
- Config: writes update key/mask/valid/aptr atomically at the clock edge, visible to S1 from next cycle. SRAM write and S2 read of same address in same cycle: read returns old data. Config writes not gated by stall.
- Reset mid-traffic: in-flight PHVs discarded, no output.

Optional Feature:
MAU_HIT_CNT_EN: adds ports cnt_rd_addr (in, $clog2(N_ENT)), cnt_rd_data (out, 32), miss_cnt (out, 32). Adds a per-entry 32-bit saturating hit counter, incremented when a PHV leaves S1 with that entry winning (not on stall cycles). Misses increment miss_cnt. Writing an entry clears its counter. cnt_rd_data is registered, 1-cycle read latency. Without the macro: no counters, no ports.

Decomposition:
- rv_p4_pkg: mau_op_e (NOP/DROP/SET_PORT/SET_FIELD/ADD_FIELD encodings), asram_entry_t {action_id, params}, OP field position constants.
- phv_meta_t already exists in rv_p4_pkg.
- One sub-module: mau_tern_match. Holds entry storage, compare and priority encoder; outputs hit, idx, aptr.

Test Plan:
- Entry0 key 0x1234<<48 exact, aid 0xA000, SRAM[1] imm=5; send matching PHV with eg_port=0 -> out eg_port=5, 4 cycles after accept.
- Entries 2 and 5 both match (entry 5 fully masked); entry 2 aid 0x9000 -> drop=1. Invalidate entry 2 -> entry 5 action applies.
- Miss with dflt_en=0 and eg_port=9 -> passthrough, eg_port=9, drop=0. With dflt_en=1 and dflt_aptr -> DROP entry -> drop=1.
- ADD_FIELD fidx=3, imm=1, PHV word3=0xFFFFFFFF -> word3=0; SET_FIELD fidx=3, imm=0xCAFEF00D -> word3=0xCAFEF00D; fidx beyond PHV -> PHV unchanged.
- Backpressure: 8 back-to-back PHVs, out_ready toggled randomly -> all 8 received in order, none duplicated, out_data stable while stalled.
- MAU_HIT_CNT_EN: 3 hits on entry0 and 2 misses -> cnt_rd_data(0)=3, miss_cnt=2. Rewrite entry0 -> count 0.

Source files
------------

// File: rtl/rv_p4_pkg.sv
// rv_p4_pkg: shared MAU types, action encodings and PHV geometry.
package rv_p4_pkg;
    localparam int PHV_BITS = 1024;
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int IMM_LSB = 16;
    localparam int IMM_W = 32;
    localparam int FIDX_W = 16;
    typedef enum logic [3:0] {
        OP_NOP       = 4'h0,
        OP_DROP      = 4'h9,
        OP_SET_PORT  = 4'hA,
        OP_SET_FIELD = 4'hB,
        OP_ADD_FIELD = 4'hC
    } mau_op_e;
    typedef struct packed {
        logic [15:0]  action_id;
        logic [111:0] params;
    } asram_entry_t;
    typedef struct packed {
        logic [9:0] ig_port;
        logic [4:0] eg_port;
        logic       drop;
    } phv_meta_t;
endpackage

// File: rtl/mau_tern_stage_match.sv
// mau_tern_match: ternary entry storage, parallel compare and lowest-index priority encode.
module mau_tern_match #(
    parameter int KEY_W = 512,
    parameter int N_ENT = 64,
    parameter int AW = 8
) (
    input  logic                     clk_dp,
    input  logic                     rst_dp_n,
    input  logic                     wr_en,
    input  logic [$clog2(N_ENT)-1:0] wr_addr,
    input  logic [KEY_W-1:0]         wr_key,
    input  logic [KEY_W-1:0]         wr_mask,
    input  logic                     wr_valid,
    input  logic [AW-1:0]            wr_aptr,
    input  logic [KEY_W-1:0]         key,
    output logic                     hit,
    output logic [$clog2(N_ENT)-1:0] idx,
    output logic [AW-1:0]            aptr
);
    localparam int IW = $clog2(N_ENT);
    logic [KEY_W-1:0] key_q [N_ENT];
    logic [KEY_W-1:0] mask_q [N_ENT];
    logic [AW-1:0] aptr_q [N_ENT];
    logic [N_ENT-1:0] valid_q;
    always_ff @(posedge clk_dp or negedge rst_dp_n)
        if (!rst_dp_n) valid_q <= '0;
        else if (wr_en) valid_q[wr_addr] <= wr_valid;
    always_ff @(posedge clk_dp)
        if (wr_en) begin
            key_q[wr_addr] <= wr_key;
            mask_q[wr_addr] <= wr_mask;
            aptr_q[wr_addr] <= wr_aptr;
        end
    // Scan downward so the lowest matching index is assigned last and wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        aptr = '0;
        for (int i = N_ENT - 1; i >= 0; i--)
            if (valid_q[i] && ((key ^ key_q[i]) & ~mask_q[i]) == '0) begin
                hit = 1'b1;
                idx = IW'(i);
                aptr = aptr_q[i];
            end
    end
endmodule

// File: rtl/mau_tern_stage.sv
// mau_tern_stage: 4-deep ternary match-action stage (capture, match, action read, ALU) with valid/ready.
// Build option MAU_HIT_CNT_EN adds per-entry hit counters, a miss counter and a counter read port.
module mau_tern_stage
    import rv_p4_pkg::*;
#(
    parameter int STAGE_ID = 0,
    parameter int KEY_W = 512,
    parameter int KEY_LSB = 0,
    parameter int N_ENT = 64,
    parameter int ASRAM_D = 256
) (
    input  logic                       clk_dp,
    input  logic                       rst_dp_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PHV_BITS-1:0]        in_data,
    input  phv_meta_t                  in_meta,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PHV_BITS-1:0]        out_data,
    output phv_meta_t                  out_meta,
    input  logic                       tcam_wr_en,
    input  logic [$clog2(N_ENT)-1:0]   tcam_wr_addr,
    input  logic [KEY_W-1:0]           tcam_wr_key,
    input  logic [KEY_W-1:0]           tcam_wr_mask,
    input  logic                       tcam_wr_valid,
    input  logic [15:0]                tcam_wr_aptr,
    input  logic                       asram_wr_en,
    input  logic [$clog2(ASRAM_D)-1:0] asram_wr_addr,
    input  logic [127:0]               asram_wr_data,
    input  logic                       dflt_en,
    input  logic [15:0]                dflt_aptr
`ifdef MAU_HIT_CNT_EN
    ,
    input  logic [$clog2(N_ENT)-1:0]   cnt_rd_addr,
    output logic [31:0]                cnt_rd_data,
    output logic [31:0]                miss_cnt
`endif
);
    localparam int IW = $clog2(N_ENT);
    localparam int AW = $clog2(ASRAM_D);
    localparam int N_WORDS = PHV_BITS / 32;
    logic stall;
    logic s0_v, s1_v, s2_v;
    logic [PHV_BITS-1:0] s0_phv, s1_phv, s2_phv, phv_n;
    phv_meta_t s0_meta, s1_meta, s2_meta, meta_n;
    logic [KEY_W-1:0] s0_key;
    logic m_hit, s1_use, s2_use;
    logic [IW-1:0] m_idx;
    logic [AW-1:0] m_aptr, s1_aptr;
    asram_entry_t asram [ASRAM_D];
    asram_entry_t s2_act;
    logic [3:0] op;
    logic [IMM_W-1:0] imm;
    logic [FIDX_W-1:0] fidx;
    logic unused;
    assign stall = out_valid & ~out_ready;
    assign in_ready = ~stall;
    mau_tern_match #(.KEY_W(KEY_W), .N_ENT(N_ENT), .AW(AW)) u_match (
        .clk_dp   (clk_dp),
        .rst_dp_n (rst_dp_n),
        .wr_en    (tcam_wr_en),
        .wr_addr  (tcam_wr_addr),
        .wr_key   (tcam_wr_key),
        .wr_mask  (tcam_wr_mask),
        .wr_valid (tcam_wr_valid),
        .wr_aptr  (tcam_wr_aptr[AW-1:0]),
        .key      (s0_key),
        .hit      (m_hit),
        .idx      (m_idx),
        .aptr     (m_aptr)
    );
    always_ff @(posedge clk_dp or negedge rst_dp_n)
        if (!rst_dp_n) begin
            s0_v <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_meta <= '0;
        end else if (!stall) begin
            s0_v <= in_valid;
            s1_v <= s0_v;
            s2_v <= s1_v;
            out_valid <= s2_v;
            if (s2_v) begin
                out_data <= phv_n;
                out_meta <= meta_n;
            end
        end
    always_ff @(posedge clk_dp)
        if (!stall) begin
            s0_phv <= in_data;
            s0_meta <= in_meta;
            s0_key <= in_data[KEY_LSB +: KEY_W];
            s1_phv <= s0_phv;
            s1_meta <= s0_meta;
            s1_use <= m_hit | dflt_en;
            s1_aptr <= m_hit ? m_aptr : dflt_aptr[AW-1:0];
            s2_phv <= s1_phv;
            s2_meta <= s1_meta;
            s2_use <= s1_use;
            s2_act <= asram[s1_aptr];
        end
    always_ff @(posedge clk_dp)
        if (asram_wr_en) asram[asram_wr_addr] <= asram_entry_t'(asram_wr_data);
    assign op = s2_use ? s2_act.action_id[OP_MSB:OP_LSB] : OP_NOP;
    assign imm = s2_act.params[IMM_LSB +: IMM_W];
    assign fidx = s2_act.params[FIDX_W-1:0];
    always_comb begin
        meta_n = s2_meta;
        meta_n.drop = (op == OP_DROP) ? 1'b1 : s2_meta.drop;
        meta_n.eg_port = (op == OP_SET_PORT) ? imm[4:0] : s2_meta.eg_port;
    end
    // An out-of-range field index selects no word, leaving the PHV untouched.
    always_comb begin
        phv_n = s2_phv;
        for (int w = 0; w < N_WORDS; w++)
            phv_n[32*w +: 32] = (fidx != FIDX_W'(w)) ? s2_phv[32*w +: 32] :
                                (op == OP_SET_FIELD) ? imm :
                                (op == OP_ADD_FIELD) ? s2_phv[32*w +: 32] + imm : s2_phv[32*w +: 32];
    end
    assign unused = ^{s2_act.action_id[11:0], s2_act.params[111:IMM_LSB+IMM_W],
                      tcam_wr_aptr[15:AW], dflt_aptr[15:AW], m_idx, STAGE_ID};
`ifdef MAU_HIT_CNT_EN
    logic s1_hit;
    logic [IW-1:0] s1_idx;
    logic [31:0] hit_cnt [N_ENT];
    // A PHV leaves S1 only on non-stall cycles, so frozen repeats are not counted.
    always_ff @(posedge clk_dp or negedge rst_dp_n)
        if (!rst_dp_n) begin
            s1_hit <= 1'b0;
            s1_idx <= '0;
            miss_cnt <= '0;
            cnt_rd_data <= '0;
            for (int i = 0; i < N_ENT; i++) hit_cnt[i] <= '0;
        end else begin
            cnt_rd_data <= hit_cnt[cnt_rd_addr];
            if (!stall) begin
                s1_hit <= m_hit;
                s1_idx <= m_idx;
            end
            if (!stall && s1_v && !s1_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            for (int i = 0; i < N_ENT; i++)
                if (tcam_wr_en && tcam_wr_addr == IW'(i)) hit_cnt[i] <= '0;
                else if (!stall && s1_v && s1_hit && s1_idx == IW'(i) && hit_cnt[i] != '1)
                    hit_cnt[i] <= hit_cnt[i] + 32'd1;
        end
`endif
endmodule

// File: tb/tb_mau_tern_stage.sv
// tb_mau_tern_stage: table-driven action vectors plus scoreboarded stall, priority and reset sequences.
module tb_mau_tern_stage;
    import rv_p4_pkg::*;
    logic clk_dp, rst_dp_n;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [PHV_BITS-1:0] in_data, out_data;
    phv_meta_t in_meta, out_meta;
    logic tcam_wr_en, tcam_wr_valid, asram_wr_en, dflt_en;
    logic [5:0] tcam_wr_addr;
    logic [511:0] tcam_wr_key, tcam_wr_mask;
    logic [15:0] tcam_wr_aptr, dflt_aptr;
    logic [7:0] asram_wr_addr;
    logic [127:0] asram_wr_data;
`ifdef MAU_HIT_CNT_EN
    logic [5:0] cnt_rd_addr;
    logic [31:0] cnt_rd_data, miss_cnt, miss_base;
`endif
    typedef struct {
        string name;
        logic [PHV_BITS-1:0] phv;
        phv_meta_t mi;
        logic dflt;
        logic [PHV_BITS-1:0] ephv;
        phv_meta_t em;
    } vec_t;
    typedef struct {
        string name;
        logic [PHV_BITS-1:0] phv;
        phv_meta_t meta;
    } exp_t;
    localparam int NV = 10;
    vec_t tv [NV];
    exp_t sb [$];
    int checks = 0, errors = 0;
    logic rnd = 1'b0;
    logic prev_stall = 1'b0;
    logic [PHV_BITS-1:0] pd;
    phv_meta_t pm;

    mau_tern_stage dut (
        .clk_dp(clk_dp), .rst_dp_n(rst_dp_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_meta(in_meta),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_meta(out_meta),
        .tcam_wr_en(tcam_wr_en), .tcam_wr_addr(tcam_wr_addr), .tcam_wr_key(tcam_wr_key),
        .tcam_wr_mask(tcam_wr_mask), .tcam_wr_valid(tcam_wr_valid), .tcam_wr_aptr(tcam_wr_aptr),
        .asram_wr_en(asram_wr_en), .asram_wr_addr(asram_wr_addr), .asram_wr_data(asram_wr_data),
        .dflt_en(dflt_en), .dflt_aptr(dflt_aptr)
`ifdef MAU_HIT_CNT_EN
        , .cnt_rd_addr(cnt_rd_addr), .cnt_rd_data(cnt_rd_data), .miss_cnt(miss_cnt)
`endif
    );

    initial clk_dp = 1'b0;
    always #5 clk_dp = ~clk_dp;

    always @(posedge clk_dp) if (rnd) begin
        #1 out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk_dp) begin
        if (rst_dp_n) begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || out_data !== pd || out_meta !== pm) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b meta got %h required %h, data_same=%0b",
                             out_valid, out_meta, pm, out_data === pd);
                end
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pm = out_meta;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got output meta %h, required no output", out_meta);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_data !== e.phv || out_meta !== e.meta) begin
                        errors++;
                        $display("FAIL %s: meta got %h required %h, word3 got %h required %h, data_eq=%0b",
                                 e.name, out_meta, e.meta, out_data[127:96], e.phv[127:96], out_data === e.phv);
                    end
                end
            end
        end else prev_stall = 1'b0;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [PHV_BITS-1:0] mk(logic [15:0] k, logic [31:0] w3);
        logic [PHV_BITS-1:0] p;
        p = '0;
        p[63:48] = k;
        p[127:96] = w3;
        p[700 +: 16] = k;
        p[1023:1008] = ~k;
        return p;
    endfunction

    function automatic phv_meta_t mm(int ig, int eg, logic d);
        phv_meta_t m;
        m.ig_port = 10'(ig);
        m.eg_port = 5'(eg);
        m.drop = d;
        return m;
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    task automatic tcam_write(int idx, logic [15:0] k, int mode, logic v, int ap);
        logic [511:0] km;
        km = '0;
        km[63:48] = '1;
        tcam_wr_addr = 6'(idx);
        tcam_wr_key = '0;
        tcam_wr_key[63:48] = k;
        tcam_wr_mask = (mode == 0) ? '0 : (mode == 1) ? ~km : '1;
        tcam_wr_valid = v;
        tcam_wr_aptr = 16'(ap);
        tcam_wr_en = 1'b1;
        @(posedge clk_dp);
        #1 tcam_wr_en = 1'b0;
    endtask

    task automatic asram_write(int a, logic [15:0] aid, logic [31:0] imm, logic [15:0] fidx);
        asram_wr_addr = 8'(a);
        asram_wr_data = {aid, 64'h0, imm, fidx};
        asram_wr_en = 1'b1;
        @(posedge clk_dp);
        #1 asram_wr_en = 1'b0;
    endtask

    task automatic send(string nm, logic [PHV_BITS-1:0] p, phv_meta_t m,
                        logic [PHV_BITS-1:0] ep, phv_meta_t em);
        int n;
        n = 0;
        in_data = p;
        in_meta = m;
        in_valid = 1'b1;
        @(negedge clk_dp);
        while (!in_ready && n < 200) begin
            @(negedge clk_dp);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: in_ready got 0 required 1 within 200 cycles", nm);
        end else sb.push_back('{nm, ep, em});
        @(posedge clk_dp);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_dp);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: outstanding got %0d required 0", nm, sb.size());
            sb.delete();
        end
        @(posedge clk_dp);
        #1;
    endtask

    initial begin
        logic [PHV_BITS-1:0] p;
        int n;
        logic seen;
        rst_dp_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_meta = '0;
        out_ready = 1'b1;
        tcam_wr_en = 1'b0;
        tcam_wr_addr = '0;
        tcam_wr_key = '0;
        tcam_wr_mask = '0;
        tcam_wr_valid = 1'b0;
        tcam_wr_aptr = '0;
        asram_wr_en = 1'b0;
        asram_wr_addr = '0;
        asram_wr_data = '0;
        dflt_en = 1'b0;
        dflt_aptr = 16'd8;
`ifdef MAU_HIT_CNT_EN
        cnt_rd_addr = '0;
`endif
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_meta", 64'(out_meta), 64'd0);
        chk("rst_out_data_zero", 64'(out_data == '0), 64'd1);
        repeat (2) @(posedge clk_dp);
        #1 rst_dp_n = 1'b1;
        @(posedge clk_dp);
        #1;
        asram_write(1, 16'hA000, 32'd5, 16'd0);
        asram_write(2, 16'h9000, 32'd0, 16'd0);
        asram_write(3, 16'hB000, 32'hCAFEF00D, 16'd3);
        asram_write(4, 16'hC000, 32'd1, 16'd3);
        asram_write(6, 16'hA000, 32'd7, 16'd0);
        asram_write(7, 16'hB000, 32'h12345678, 16'd40);
        asram_write(8, 16'h9000, 32'd0, 16'd0);
        asram_write(9, 16'h5000, 32'hFFFFFFFF, 16'd3);
        tcam_write(0, 16'h1234, 0, 1'b1, 1);
        tcam_write(1, 16'h1111, 1, 1'b1, 7);
        tcam_write(2, 16'h2222, 1, 1'b1, 2);
        tcam_write(3, 16'h3333, 1, 1'b1, 3);
        tcam_write(4, 16'h4444, 1, 1'b1, 4);
        tcam_write(6, 16'h6666, 1, 1'b1, 9);
        p = mk(16'h1234, 32'd0);
        p[5] = 1'b1;
        tv[0] = '{"set_port", mk(16'h1234, 32'd0), mm(1, 0, 0), 1'b0, mk(16'h1234, 32'd0), mm(1, 5, 0)};
        tv[1] = '{"drop", mk(16'h2222, 32'd7), mm(2, 4, 0), 1'b0, mk(16'h2222, 32'd7), mm(2, 4, 1)};
        tv[2] = '{"set_field", mk(16'h3333, 32'h11111111), mm(3, 1, 0), 1'b0, mk(16'h3333, 32'hCAFEF00D), mm(3, 1, 0)};
        tv[3] = '{"add_wrap", mk(16'h4444, 32'hFFFFFFFF), mm(4, 2, 0), 1'b0, mk(16'h4444, 32'd0), mm(4, 2, 0)};
        tv[4] = '{"add_field", mk(16'h4444, 32'h10), mm(4, 2, 0), 1'b0, mk(16'h4444, 32'h11), mm(4, 2, 0)};
        tv[5] = '{"fidx_oob", mk(16'h1111, 32'hABCD), mm(5, 3, 0), 1'b0, mk(16'h1111, 32'hABCD), mm(5, 3, 0)};
        tv[6] = '{"other_op", mk(16'h6666, 32'h55), mm(6, 2, 0), 1'b0, mk(16'h6666, 32'h55), mm(6, 2, 0)};
        tv[7] = '{"miss_pass", mk(16'h5555, 32'h77), mm(7, 9, 0), 1'b0, mk(16'h5555, 32'h77), mm(7, 9, 0)};
        tv[8] = '{"exact_miss", p, mm(8, 0, 0), 1'b0, p, mm(8, 0, 0)};
        tv[9] = '{"miss_dflt", mk(16'h5555, 32'h77), mm(9, 9, 0), 1'b1, mk(16'h5555, 32'h77), mm(9, 9, 1)};
        for (int i = 0; i < NV; i++) begin
            dflt_en = tv[i].dflt;
            send(tv[i].name, tv[i].phv, tv[i].mi, tv[i].ephv, tv[i].em);
            if (i == 0) begin
                n = 0;
                do begin
                    @(negedge clk_dp);
                    n++;
                end while (!out_valid && n < 10);
                chk("latency", 64'(n), 64'd4);
            end
            drain(tv[i].name);
        end
        dflt_en = 1'b0;
        tcam_write(5, 16'h0, 2, 1'b1, 6);
        send("prio_low_idx", mk(16'h2222, 32'd7), mm(2, 4, 0), mk(16'h2222, 32'd7), mm(2, 4, 1));
        drain("prio_low_idx");
        tcam_write(2, 16'h2222, 1, 1'b0, 2);
        send("prio_fallthru", mk(16'h2222, 32'd7), mm(2, 4, 0), mk(16'h2222, 32'd7), mm(2, 7, 0));
        drain("prio_fallthru");
        out_ready = 1'b0;
        send("hold", mk(16'h4444, 32'd5), mm(3, 1, 0), mk(16'h4444, 32'd6), mm(3, 1, 0));
        repeat (8) @(posedge clk_dp);
        #1 out_ready = 1'b1;
        drain("hold");
        rnd = 1'b1;
        for (int i = 0; i < 8; i++)
            send($sformatf("bp%0d", i), mk(16'h4444, 32'(i * 3)), mm(i, i, 0),
                 mk(16'h4444, 32'(i * 3 + 1)), mm(i, i, 0));
        rnd = 1'b0;
        @(posedge clk_dp);
        #2 out_ready = 1'b1;
        drain("bp");
`ifdef MAU_HIT_CNT_EN
        tcam_write(5, 16'h0, 2, 1'b0, 6);
        tcam_write(0, 16'h1234, 0, 1'b1, 1);
        miss_base = miss_cnt;
        for (int i = 0; i < 3; i++)
            send("cnt_hit", mk(16'h1234, 32'd0), mm(1, 0, 0), mk(16'h1234, 32'd0), mm(1, 5, 0));
        for (int i = 0; i < 2; i++)
            send("cnt_miss", mk(16'h5555, 32'd1), mm(1, 9, 0), mk(16'h5555, 32'd1), mm(1, 9, 0));
        drain("cnt");
        cnt_rd_addr = 6'd0;
        repeat (2) @(posedge clk_dp);
        #1;
        chk("hit_cnt0", 64'(cnt_rd_data), 64'd3);
        chk("miss_cnt_delta", 64'(miss_cnt - miss_base), 64'd2);
        tcam_write(0, 16'h1234, 0, 1'b1, 1);
        repeat (2) @(posedge clk_dp);
        #1;
        chk("hit_cnt0_cleared", 64'(cnt_rd_data), 64'd0);
`endif
        send("flush_a", mk(16'h4444, 32'd1), mm(1, 1, 0), mk(16'h4444, 32'd2), mm(1, 1, 0));
        send("flush_b", mk(16'h4444, 32'd2), mm(1, 1, 0), mk(16'h4444, 32'd3), mm(1, 1, 0));
        rst_dp_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk_dp);
        #1 rst_dp_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk_dp);
            if (out_valid) seen = 1'b1;
        end
        chk("reset_flush", 64'(seen), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
